param_fifo: RTL and testbench

Parametrised synchronous FIFO, the successor to the fixed-size lab FIFO. It has configurable data width and depth, occupancy count, programmable almost-full/almost-empty flags and a synchronous flush. It sits between a valid/ready producer and a valid/yumi consumer, and is the buffering primitive for later lab datapaths.

---
 rtl/param_fifo.sv | 93 +++++++++
 tb/tb_param_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// param_fifo: parametrised first-word-fall-through FIFO with occupancy count,
// almost-full/almost-empty flags and a synchronous flush. The producer side uses
// valid/ready and the consumer side uses valid/yumi.
module param_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = DEPTH - 1,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_i,
  output logic                       rdy,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       valid_o,
  input  logic                       yumi,
  output logic [WIDTH-1:0]           data_o,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfCnt    = CntW'(AF_THRESH);
  localparam logic [CntW-1:0] AeCnt    = CntW'(AE_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             wr_en, rd_en;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // Handshake decode: both sides look only at the registered count.
  always_comb begin
    wr_en = valid_i & rdy;
    rd_en = yumi & valid_o;
  end

  // Next pointers and occupancy; flush wins over any concurrent write or read.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(wr_en) - CntW'(rd_en);
    end
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; contents past the read pointer are never observed.
  always_ff @(posedge clk) begin
    if (wr_en && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Status and head-of-queue outputs, all derived from registered state.
  always_comb begin
    rdy            = (count_q != DepthCnt);
    valid_o        = (count_q != '0);
    data_o         = valid_o ? mem_q[rd_ptr_q] : '0;
    count_o        = count_q;
    almost_full_o  = (count_q >= AfCnt);
    almost_empty_o = (count_q <= AeCnt);
  end

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: a vector table plus hand sequences on a DEPTH=8 pair
// (default and 6/2 thresholds, shared inputs), and queue-model random runs on
// DEPTH=8 and DEPTH=5 instances.
module tb_param_fifo;

  logic clk;
  logic reset;

  // Group A drives two DEPTH=8 instances that differ only in flag thresholds.
  logic       a_valid, a_yumi, a_flush;
  logic [7:0] a_data;
  logic       a_rdy, a_vo, a_af, a_ae;
  logic [7:0] a_do;
  logic [3:0] a_cnt;
  logic       t_rdy, t_vo, t_af, t_ae;
  logic [7:0] t_do;
  logic [3:0] t_cnt;

  // Group B drives the DEPTH=5 instance.
  logic       b_valid, b_yumi, b_flush;
  logic [7:0] b_data;
  logic       b_rdy, b_vo, b_af, b_ae;
  logic [7:0] b_do;
  logic [2:0] b_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  param_fifo #(.WIDTH(8), .DEPTH(8)) u8 (
    .clk(clk), .reset(reset), .valid_i(a_valid), .rdy(a_rdy), .data_i(a_data),
    .valid_o(a_vo), .yumi(a_yumi), .data_o(a_do), .flush_i(a_flush), .count_o(a_cnt),
    .almost_full_o(a_af), .almost_empty_o(a_ae)
  );

  param_fifo #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) u8t (
    .clk(clk), .reset(reset), .valid_i(a_valid), .rdy(t_rdy), .data_i(a_data),
    .valid_o(t_vo), .yumi(a_yumi), .data_o(t_do), .flush_i(a_flush), .count_o(t_cnt),
    .almost_full_o(t_af), .almost_empty_o(t_ae)
  );

  param_fifo #(.WIDTH(8), .DEPTH(5)) u5 (
    .clk(clk), .reset(reset), .valid_i(b_valid), .rdy(b_rdy), .data_i(b_data),
    .valid_o(b_vo), .yumi(b_yumi), .data_o(b_do), .flush_i(b_flush), .count_o(b_cnt),
    .almost_full_o(b_af), .almost_empty_o(b_ae)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       y;
    logic       f;
    int         cnt;
    int         head;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] d, input logic y, input logic f,
                     input int cnt, input int head);
    vec_t e;
    e.v = v; e.d = d; e.y = y; e.f = f; e.cnt = cnt; e.head = head;
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Full observable state of both group-A instances against an expected occupancy/head.
  task automatic check_a(input string name, input int cnt, input int head);
    check({name, " cnt"},     int'(a_cnt), cnt);
    check({name, " rdy"},     int'(a_rdy), int'(cnt != 8));
    check({name, " valid_o"}, int'(a_vo),  int'(cnt != 0));
    check({name, " data_o"},  int'(a_do),  (cnt != 0) ? head : 0);
    check({name, " af"},      int'(a_af),  int'(cnt >= 7));
    check({name, " ae"},      int'(a_ae),  int'(cnt <= 1));
    check({name, " t_cnt"},   int'(t_cnt), cnt);
    check({name, " t_af"},    int'(t_af),  int'(cnt >= 6));
    check({name, " t_ae"},    int'(t_ae),  int'(cnt <= 2));
  endtask

  task automatic check_b(input string name, input int cnt, input int head);
    check({name, " cnt"},     int'(b_cnt), cnt);
    check({name, " rdy"},     int'(b_rdy), int'(cnt != 5));
    check({name, " valid_o"}, int'(b_vo),  int'(cnt != 0));
    check({name, " data_o"},  int'(b_do),  (cnt != 0) ? head : 0);
    check({name, " af"},      int'(b_af),  int'(cnt >= 4));
    check({name, " ae"},      int'(b_ae),  int'(cnt <= 1));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs sampled 1 unit after the next.
  task automatic a_step(input logic v, input logic [7:0] d, input logic y, input logic f);
    a_valid = v; a_data = d; a_yumi = y; a_flush = f;
    @(posedge clk);
    #1;
  endtask

  byte unsigned aq[$];
  byte unsigned bq[$];

  initial begin
    int out_cnt;
    int next_w;
    int cyc;
    logic wr, rd;

    a_valid = 0; a_data = 0; a_yumi = 0; a_flush = 0;
    b_valid = 0; b_data = 0; b_yumi = 0; b_flush = 0;
    reset = 1'b1;
    #2;
    check("rdy during reset", int'(a_rdy), 1);
    check("b rdy during reset", int'(b_rdy), 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_a("reset state", 0, 0);
    check_b("b reset state", 0, 0);

    // Vector table: fill, overfill, drain, empty read, and simultaneous events.
    for (int i = 0; i < 8; i++) add(1'b1, 8'(i + 1), 1'b0, 1'b0, i + 1, 8'h01);
    add(1'b1, 8'h09, 1'b0, 1'b0, 8, 8'h01);
    for (int k = 0; k < 8; k++) add(1'b0, 8'h00, 1'b1, 1'b0, 7 - k, (k < 7) ? k + 2 : 0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 0, 0);
    add(1'b1, 8'hA1, 1'b1, 1'b0, 1, 8'hA1);
    add(1'b1, 8'hA2, 1'b0, 1'b0, 2, 8'hA1);
    add(1'b1, 8'hA3, 1'b0, 1'b0, 3, 8'hA1);
    add(1'b1, 8'hA4, 1'b0, 1'b0, 4, 8'hA1);
    add(1'b1, 8'hA5, 1'b1, 1'b0, 4, 8'hA2);
    for (int i = 0; i < 4; i++) add(1'b1, 8'(8'hA6 + i), 1'b0, 1'b0, 5 + i, 8'hA2);
    add(1'b1, 8'hB0, 1'b1, 1'b0, 7, 8'hA3);
    for (int k = 0; k < 7; k++) add(1'b0, 8'h00, 1'b1, 1'b0, 6 - k, (k < 6) ? 8'hA4 + k : 0);

    foreach (tbl[i]) begin
      a_step(tbl[i].v, tbl[i].d, tbl[i].y, tbl[i].f);
      check_a($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].head);
    end

    // Asynchronous reset with three words stored, asserted away from any edge.
    a_step(1'b1, 8'h21, 1'b0, 1'b0);
    a_step(1'b1, 8'h22, 1'b0, 1'b0);
    a_step(1'b1, 8'h23, 1'b0, 1'b0);
    a_valid = 0;
    check_a("pre-reset", 3, 8'h21);
    #2;
    reset = 1'b1;
    #1;
    check("async reset cnt", int'(a_cnt), 0);
    check("async reset rdy", int'(a_rdy), 1);
    check("async reset valid_o", int'(a_vo), 0);
    check("async reset data_o", int'(a_do), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_a("after reset release", 0, 0);

    // Flush with a concurrent write and read: nothing survives, 0xAA is dropped.
    for (int i = 0; i < 5; i++) a_step(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
    check_a("pre-flush", 5, 8'h31);
    a_step(1'b1, 8'hAA, 1'b1, 1'b1);
    check_a("after flush", 0, 0);
    a_step(1'b1, 8'h55, 1'b0, 1'b0);
    check_a("post-flush write", 1, 8'h55);
    a_step(1'b0, 8'h00, 1'b1, 1'b0);
    check_a("post-flush drain", 0, 0);

    // Random traffic on DEPTH=8 against a queue model, with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      logic v, y, f;
      logic [7:0] d;
      v = ($urandom_range(0, 99) < 60);
      y = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 39) == 0);
      d = 8'($urandom);
      wr = v && (aq.size() < 8);
      rd = y && (aq.size() > 0);
      if (f) aq.delete();
      else begin
        if (rd) void'(aq.pop_front());
        if (wr) aq.push_back(d);
      end
      a_step(v, d, y, f);
      check_a("rand8", aq.size(), (aq.size() > 0) ? int'(aq[0]) : 0);
    end
    a_step(1'b0, 8'h00, 1'b0, 1'b1);

    // DEPTH=5 stream of 0x10..0x23 across several pointer wraps.
    out_cnt = 0;
    next_w  = 8'h10;
    cyc     = 0;
    @(posedge clk);
    #1;
    while (out_cnt < 20 && cyc < 2000) begin
      b_valid = (next_w <= 8'h23) && ($urandom_range(0, 99) < 65);
      b_data  = 8'(next_w);
      b_yumi  = ($urandom_range(0, 99) < 50);
      wr = b_valid && (bq.size() < 5);
      rd = b_yumi && (bq.size() > 0);
      if (rd) begin
        check("b order", int'(b_do), 8'h10 + out_cnt);
        void'(bq.pop_front());
        out_cnt++;
      end
      if (wr) begin
        bq.push_back(8'(next_w));
        next_w++;
      end
      @(posedge clk);
      #1;
      check_b("rand5", bq.size(), (bq.size() > 0) ? int'(bq[0]) : 0);
      cyc++;
    end
    b_valid = 0;
    b_yumi  = 0;
    check("b words delivered", out_cnt, 20);
    check("b words accepted", next_w, 8'h24);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
